vcu108_stress_test_pll_drp: RTL and testbench

DRP initiator that reprograms the CLKOUT0 divider of the stress-test PLLE3_ADV at run time, so the stress clock frequency can change without a new bitstream.
- Accepts a divide value over a valid/ready handshake.
- Holds the PLL in reset during the update.
- Performs read-modify-write of ClkReg1/ClkReg2 over DRP.
- Releases reset and waits for LOCKED.
- Sits in the DCLK domain beside the PLL wrapper, which exposes its DRP ports and RST.

---
 rtl/vcu108_stress_test_pll_drp_pkg.sv | 77 +++++++
 rtl/vcu108_stress_test_sync2.sv | 21 ++
 rtl/vcu108_stress_test_pll_drp.sv | 208 ++++++++++++++++++++
 tb/tb_vcu108_stress_test_pll_drp.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcu108_stress_test_pll_drp_pkg.sv
// Shared constants, FSM states and CLKOUT0 divider field helpers for the
// stress-test PLL DRP reprogrammer.
package vcu108_stress_test_pll_drp_pkg;

   localparam int unsigned DRP_AW = 7;
   localparam int unsigned DRP_DW = 16;
   localparam int unsigned DIV_W  = 8;

   localparam logic [DRP_AW-1:0] CLKREG1_ADDR = 7'h08;
   localparam logic [DRP_AW-1:0] CLKREG2_ADDR = 7'h09;
   localparam int unsigned       EDGE_BIT     = 10;
   localparam int unsigned       NO_COUNT_BIT = 11;
   localparam logic [DIV_W-1:0]  DIV_MAX      = 8'd128;

   typedef enum logic [1:0] {
      ERR_NONE         = 2'd0,
      ERR_DIVIDE       = 2'd1,
      ERR_DRP_TIMEOUT  = 2'd2,
      ERR_LOCK_TIMEOUT = 2'd3
   } err_code_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HOLD,
      ST_RD1,
      ST_WT1,
      ST_WR1,
      ST_WW1,
      ST_RD2,
      ST_WT2,
      ST_WR2,
      ST_WW2,
      ST_RELEASE,
      ST_LOCK,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [5:0] high_time;
      logic [5:0] low_time;
      logic       edge_sel;
      logic       no_count;
   } clkout_fields_t;

   // Counter fields are 6 bits wide, so a count of 64 wraps to 0 as the PLL expects.
   // Edge is forced low for divide 1 because the counter is bypassed entirely.
   function automatic clkout_fields_t calc_fields(input logic [DIV_W-1:0] d);
      clkout_fields_t f;
      logic [DIV_W-1:0] hi;
      logic [DIV_W-1:0] lo;
      hi          = d >> 1;
      lo          = d - hi;
      f.high_time = 6'(hi);
      f.low_time  = 6'(lo);
      f.no_count  = (d == 8'd1);
      f.edge_sel  = d[0] & ~f.no_count;
      return f;
   endfunction

   function automatic logic [DRP_DW-1:0] merge_clkreg1(input logic [DRP_DW-1:0] rd,
                                                      input clkout_fields_t     f);
      logic [DRP_DW-1:0] w;
      w       = rd;
      w[11:0] = {f.high_time, f.low_time};
      return w;
   endfunction

   function automatic logic [DRP_DW-1:0] merge_clkreg2(input logic [DRP_DW-1:0] rd,
                                                      input clkout_fields_t     f);
      logic [DRP_DW-1:0] w;
      w               = rd;
      w[EDGE_BIT]     = f.edge_sel;
      w[NO_COUNT_BIT] = f.no_count;
      return w;
   endfunction

endpackage

// File: rtl/vcu108_stress_test_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCKED into the DCLK domain.
module vcu108_stress_test_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vcu108_stress_test_pll_drp.sv
// DRP initiator: holds the stress PLL in reset, read-modify-writes the CLKOUT0
// divider registers, then releases reset and waits for a fresh lock.
module vcu108_stress_test_pll_drp
   import vcu108_stress_test_pll_drp_pkg::*;
#(
   parameter int unsigned DRP_TIMEOUT  = 16,
   parameter int unsigned LOCK_TIMEOUT = 65536,
   parameter int unsigned RST_HOLD     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DIV_W-1:0]  cfg_divide,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [DRP_AW-1:0] drp_addr,
   output logic              drp_en,
   output logic              drp_we,
   output logic [DRP_DW-1:0] drp_di,
   input  logic [DRP_DW-1:0] drp_do,
   input  logic              drp_rdy,
   output logic              pll_rst,
   input  logic              pll_locked
);

   localparam int unsigned MAX_A        = (DRP_TIMEOUT > RST_HOLD) ? DRP_TIMEOUT : RST_HOLD;
   localparam int unsigned MAX_CNT      = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
   localparam int unsigned CNT_W        = $clog2(MAX_CNT + 1);
   localparam int unsigned BLANK_CYCLES = 3;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [DRP_DW-1:0]   rd_q, rd_d;
   logic                seen_low_q, seen_low_d;
   logic                locked_s;
   clkout_fields_t      fields;

   logic                cfg_ready_d, busy_d, done_d, err_d;
   logic [1:0]          err_code_d;
   logic [DRP_AW-1:0]   drp_addr_d;
   logic                drp_en_d, drp_we_d;
   logic [DRP_DW-1:0]   drp_di_d;
   logic                pll_rst_d;
   logic                drp_expired, lock_expired, hold_done, lock_ok;

   vcu108_stress_test_sync2 u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         div_q      <= '0;
         rd_q       <= '0;
         seen_low_q <= 1'b0;
         cfg_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
         drp_addr   <= '0;
         drp_en     <= 1'b0;
         drp_we     <= 1'b0;
         drp_di     <= '0;
         pll_rst    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         rd_q       <= rd_d;
         seen_low_q <= seen_low_d;
         cfg_ready  <= cfg_ready_d;
         busy       <= busy_d;
         done       <= done_d;
         err        <= err_d;
         err_code   <= err_code_d;
         drp_addr   <= drp_addr_d;
         drp_en     <= drp_en_d;
         drp_we     <= drp_we_d;
         drp_di     <= drp_di_d;
         pll_rst    <= pll_rst_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      div_d        = div_q;
      rd_d         = rd_q;
      err_d        = err;
      err_code_d   = err_code;
      drp_addr_d   = drp_addr;
      drp_di_d     = drp_di;
      fields       = calc_fields(div_q);
      drp_expired  = (cnt_q == CNT_W'(DRP_TIMEOUT - 1));
      lock_expired = (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
      hold_done    = (cnt_q == CNT_W'(RST_HOLD - 1));
      // A lock only counts once it was seen low under reset and the blanking window has passed.
      lock_ok      = locked_s && seen_low_q && (cnt_q >= CNT_W'(BLANK_CYCLES));
      seen_low_d   = seen_low_q | (pll_rst & ~locked_s);

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_valid && cfg_ready) begin
               if ((cfg_divide == '0) || (cfg_divide > DIV_MAX)) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_DIVIDE;
               end else begin
                  err_d      = 1'b0;
                  err_code_d = ERR_NONE;
                  div_d      = cfg_divide;
                  seen_low_d = 1'b0;
                  state_d    = ST_HOLD;
               end
            end
         end
         ST_HOLD: if (hold_done) state_d = ST_RD1;
         ST_RD1:  state_d = ST_WT1;
         ST_WT1: begin
            if (drp_rdy) begin
               rd_d    = drp_do;
               state_d = ST_WR1;
            end else if (drp_expired) begin
               err_d      = 1'b1;
               err_code_d = ERR_DRP_TIMEOUT;
               state_d    = ST_IDLE;
            end
         end
         ST_WR1: state_d = ST_WW1;
         ST_WW1: begin
            if (drp_rdy) begin
               state_d = ST_RD2;
            end else if (drp_expired) begin
               err_d      = 1'b1;
               err_code_d = ERR_DRP_TIMEOUT;
               state_d    = ST_IDLE;
            end
         end
         ST_RD2: state_d = ST_WT2;
         ST_WT2: begin
            if (drp_rdy) begin
               rd_d    = drp_do;
               state_d = ST_WR2;
            end else if (drp_expired) begin
               err_d      = 1'b1;
               err_code_d = ERR_DRP_TIMEOUT;
               state_d    = ST_IDLE;
            end
         end
         ST_WR2: state_d = ST_WW2;
         ST_WW2: begin
            if (drp_rdy) begin
               state_d = ST_RELEASE;
            end else if (drp_expired) begin
               err_d      = 1'b1;
               err_code_d = ERR_DRP_TIMEOUT;
               state_d    = ST_IDLE;
            end
         end
         ST_RELEASE: state_d = ST_LOCK;
         ST_LOCK: begin
            if (lock_ok) begin
               state_d = ST_DONE;
            end else if (lock_expired) begin
               err_d      = 1'b1;
               err_code_d = ERR_LOCK_TIMEOUT;
               state_d    = ST_IDLE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if ((state_d != state_q) || (state_d == ST_IDLE)) begin
         cnt_d = '0;
      end

      // Registered outputs are decoded from the next state so they align with it.
      cfg_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      pll_rst_d   = state_d inside {ST_HOLD, ST_RD1, ST_WT1, ST_WR1, ST_WW1,
                                    ST_RD2, ST_WT2, ST_WR2, ST_WW2};
      drp_en_d    = state_d inside {ST_RD1, ST_WR1, ST_RD2, ST_WR2};
      drp_we_d    = state_d inside {ST_WR1, ST_WR2};

      if (state_d inside {ST_RD1, ST_WR1}) begin
         drp_addr_d = CLKREG1_ADDR;
      end else if (state_d inside {ST_RD2, ST_WR2}) begin
         drp_addr_d = CLKREG2_ADDR;
      end

      if (state_d == ST_WR1) begin
         drp_di_d = merge_clkreg1(rd_d, fields);
      end else if (state_d == ST_WR2) begin
         drp_di_d = merge_clkreg2(rd_d, fields);
      end
   end

endmodule

// File: tb/tb_vcu108_stress_test_pll_drp.sv
// Directed bench for the PLL DRP reprogrammer with a DRP slave and PLL lock model.
module tb_vcu108_stress_test_pll_drp;

   localparam int unsigned DRP_TIMEOUT  = 16;
   localparam int unsigned LOCK_TIMEOUT = 300;
   localparam int unsigned RST_HOLD     = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [7:0]  cfg_divide;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [6:0]  drp_addr;
   logic        drp_en;
   logic        drp_we;
   logic [15:0] drp_di;
   logic [15:0] drp_do = 16'h0000;
   logic        drp_rdy = 1'b0;
   logic        pll_rst;
   logic        pll_locked = 1'b1;

   int checks = 0;
   int failures = 0;

   // Stimulus-side controls for the models
   logic [15:0] mem8, mem9;
   bit          stall8 = 1'b0;
   bit          lock_off = 1'b0;
   int          lat = 2;

   // Monitor-side observations
   logic [22:0] obs_wr[$];
   int          en_cnt = 0;
   int          done_cnt = 0;
   int          rst_hi_cnt = 0;
   int          rst_run = 0;
   int          first_en_rst = 0;
   int          proto_err = 0;
   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [15:0] pend_data = 16'h0000;
   bit          prev_en = 1'b0;
   int          lk_cnt = 0;

   // Expected DRP writes, consumed in order
   logic [22:0] sb[$];
   int          obs_rd = 0;

   always #5 clk = ~clk;

   vcu108_stress_test_pll_drp #(
      .DRP_TIMEOUT  (DRP_TIMEOUT),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .RST_HOLD     (RST_HOLD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_divide (cfg_divide),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_code   (err_code),
      .drp_addr   (drp_addr),
      .drp_en     (drp_en),
      .drp_we     (drp_we),
      .drp_di     (drp_di),
      .drp_do     (drp_do),
      .drp_rdy    (drp_rdy),
      .pll_rst    (pll_rst),
      .pll_locked (pll_locked)
   );

   // DRP slave model plus protocol/activity monitor
   always @(negedge clk) begin
      drp_rdy = 1'b0;
      if (!rst_n) begin
         pend    = 1'b0;
         prev_en = 1'b0;
         rst_run = 0;
      end else begin
         if (done) done_cnt++;
         if (pll_rst) begin
            rst_hi_cnt++;
            rst_run++;
         end else begin
            rst_run = 0;
         end
         if (drp_we && !drp_en) proto_err++;
         if (drp_en && prev_en) proto_err++;
         prev_en = drp_en;
         if (pend) begin
            if (pend_cnt <= 1) begin
               drp_rdy = 1'b1;
               drp_do  = pend_data;
               pend    = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (drp_en) begin
            en_cnt++;
            if (pend) proto_err++;
            if (drp_we) begin
               if (!pll_rst) proto_err++;
               obs_wr.push_back({drp_addr, drp_di});
               pend_data = 16'h0000;
            end else if (drp_addr == 7'h08) begin
               first_en_rst = rst_run;
               pend_data    = mem8;
            end else begin
               pend_data = mem9;
            end
            if (!(stall8 && !drp_we && drp_addr == 7'h08)) begin
               pend     = 1'b1;
               pend_cnt = lat;
            end
         end
      end
   end

   // PLL lock model: drops under reset, relocks 10 cycles after release
   always @(negedge clk) begin
      if (pll_rst || lock_off) begin
         pll_locked = 1'b0;
         lk_cnt     = 0;
      end else if (lk_cnt < 10) begin
         lk_cnt++;
      end else begin
         pll_locked = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   task automatic drain_sb();
      logic [22:0] exp_wr;
      logic [22:0] got_wr;
      while (sb.size() != 0) begin
         exp_wr = sb.pop_front();
         got_wr = (obs_rd < obs_wr.size()) ? obs_wr[obs_rd] : 23'h7FFFFF;
         obs_rd++;
         check("drp_write", 32'(got_wr), 32'(exp_wr));
      end
      check("write_count", obs_wr.size(), obs_rd);
      check("drp_protocol", proto_err, 0);
   endtask

   task automatic do_req(input logic [7:0] d);
      int n = 0;
      while (!cfg_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_req", cfg_ready, 1);
      cfg_divide = d;
      cfg_valid  = 1'b1;
      @(negedge clk);
      cfg_valid  = 1'b0;
      cfg_divide = ~d;
   endtask

   task automatic run_ok(input logic [7:0] d, input logic [15:0] r8, input logic [15:0] r9,
                         input logic [15:0] e8, input logic [15:0] e9);
      int n;
      int d0;
      mem8 = r8;
      mem9 = r9;
      lat  = $urandom_range(1, 4);
      sb.push_back({7'h08, e8});
      sb.push_back({7'h09, e9});
      d0 = done_cnt;
      do_req(d);
      check("err_clear_on_accept", err, 0);
      check("busy_after_accept", busy, 1);
      n = 0;
      while (!done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1);
      repeat (3) @(negedge clk);
      check("done_pulse_count", done_cnt - d0, 1);
      check("err_after_done", err, 0);
      check("pll_rst_after_done", pll_rst, 0);
      check("ready_after_done", cfg_ready, 1);
      check("rst_hold_before_rd1", first_en_rst, RST_HOLD + 1);
      drain_sb();
   endtask

   task automatic run_bad(input logic [7:0] d);
      int en0;
      int rh0;
      int d0;
      int w0;
      en0 = en_cnt;
      rh0 = rst_hi_cnt;
      d0  = done_cnt;
      w0  = obs_wr.size();
      do_req(d);
      check("bad_div_err", err, 1);
      check("bad_div_code", err_code, 1);
      check("bad_div_ready", cfg_ready, 1);
      check("bad_div_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("bad_div_no_drp", en_cnt - en0, 0);
      check("bad_div_no_pll_rst", rst_hi_cnt - rh0, 0);
      check("bad_div_no_done", done_cnt - d0, 0);
      check("bad_div_no_write", obs_wr.size() - w0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int d0;
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_divide = 8'd0;
      mem8       = 16'h0000;
      mem9       = 16'h0000;
      repeat (3) @(negedge clk);

      check("rst_pll_rst", pll_rst, 0);
      check("rst_drp_en", drp_en, 0);
      check("rst_drp_we", drp_we, 0);
      check("rst_drp_addr", drp_addr, 0);
      check("rst_drp_di", drp_di, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_busy", busy, 0);
      check("rst_cfg_ready", cfg_ready, 1);

      rst_n = 1'b1;
      @(negedge clk);

      run_ok(8'd12,  16'hF000, 16'h0000, 16'hF186, 16'h0000);
      run_ok(8'd7,   16'hA000, 16'h00FF, 16'hA0C4, 16'h04FF);
      run_ok(8'd1,   16'h0000, 16'h0000, 16'h0001, 16'h0800);
      run_ok(8'd128, 16'hF000, 16'h0C00, 16'hF000, 16'h0000);
      run_ok(8'd64,  16'h1FFF, 16'hFFFF, 16'h1820, 16'hF3FF);

      run_bad(8'd0);
      run_bad(8'd200);
      run_bad(8'd129);
      run_ok(8'd12, 16'hF000, 16'h0000, 16'hF186, 16'h0000);

      // DRP read of ClkReg1 never answered
      stall8 = 1'b1;
      d0 = done_cnt;
      do_req(8'd12);
      n = 0;
      while (!drp_en && n < 200) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!err && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drp_timeout_cycles", n, DRP_TIMEOUT + 1);
      check("drp_timeout_code", err_code, 2);
      check("drp_timeout_pll_rst", pll_rst, 0);
      check("drp_timeout_ready", cfg_ready, 1);
      check("drp_timeout_no_done", done_cnt - d0, 0);
      stall8 = 1'b0;
      drain_sb();

      run_ok(8'd64, 16'h1FFF, 16'hFFFF, 16'h1820, 16'hF3FF);

      // PLL never relocks
      lock_off = 1'b1;
      mem8 = 16'hF000;
      mem9 = 16'h0000;
      lat  = 2;
      sb.push_back({7'h08, 16'hF186});
      sb.push_back({7'h09, 16'h0000});
      d0 = done_cnt;
      do_req(8'd12);
      n = 0;
      while (!pll_rst && n < 100) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (pll_rst && n < 500) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!err && n < int'(LOCK_TIMEOUT) + 100) begin
         @(negedge clk);
         n++;
      end
      check("lock_timeout_cycles", n, LOCK_TIMEOUT + 1);
      check("lock_timeout_code", err_code, 3);
      check("lock_timeout_pll_rst", pll_rst, 0);
      check("lock_timeout_ready", cfg_ready, 1);
      check("lock_timeout_no_done", done_cnt - d0, 0);
      drain_sb();
      lock_off = 1'b0;

      // Reset asserted while waiting on the ClkReg2 read
      mem8 = 16'hF000;
      mem9 = 16'h00FF;
      lat  = 2;
      sb.push_back({7'h08, 16'hF0C4});
      do_req(8'd7);
      n = 0;
      while (!(drp_en && !drp_we && drp_addr == 7'h09) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reached_rd2", 32'(drp_en & ~drp_we & (drp_addr == 7'h09)), 1);
      @(negedge clk);
      check("pll_rst_in_wt2", pll_rst, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_pll_rst", pll_rst, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ready", cfg_ready, 1);
      check("midrst_drp_en", drp_en, 0);
      check("midrst_drp_addr", drp_addr, 0);
      check("midrst_drp_di", drp_di, 0);
      check("midrst_err", err, 0);
      check("midrst_done", done, 0);
      repeat (2) @(negedge clk);
      drain_sb();
      rst_n = 1'b1;
      @(negedge clk);

      run_ok(8'd7, 16'hA000, 16'h00FF, 16'hA0C4, 16'h04FF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
